// File: rtl/stream_link_pkg.sv
// Shared definitions for the word/beat stream link (serializer and receiver).
// Holds default word/beat widths, the derived beat count and beat index width,
// word/beat typedefs and the transmit FSM state encoding.
package stream_link_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_BEAT_W = 8;

  // Beat index width; a single-beat word still gets a 1-bit index.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int DEF_BEATS = DEF_WORD_W / DEF_BEAT_W;
  localparam int DEF_IDX_W = idx_width(DEF_BEATS);

  typedef logic [DEF_BEAT_W-1:0] beat_t;
  typedef logic [DEF_WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/stream_beat_counter.sv
// Beat index register for the serializer: clear to 0, or step by one up to BEATS-1.
// Ports: i_clk/i_rst (sync, active-high), i_inc/i_clr controls, o_idx current index,
//        o_first (idx==0), o_last (idx==BEATS-1). Flags are unqualified by valid.
module stream_beat_counter #(
  parameter int BEATS = 4,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_first,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [IDX_W-1:0] r_idx;

  // Clear wins over increment; the index saturates at LAST_IDX so it can never
  // wander past the final beat even if inc were asserted there.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_idx <= '0;
    end else if (i_inc && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_idx   = r_idx;
  assign o_first = (r_idx == '0);
  assign o_last  = (r_idx == LAST_IDX);

endmodule

// File: rtl/stream_word_serializer_tx.sv
// Word-to-beat serializer: takes one WORD_W word per handshake and sends it as
// WORD_W/BEAT_W beats, LSB beat first. Beat 0 appears the cycle after the word
// handshake; a new word can be taken on the last-beat handshake (no bubble).
// Ports: i_clk/i_rst (sync, active-high); word side i_word_valid/o_word_ready/
//        i_word_data; beat side o_beat_valid/i_beat_ready/o_beat_data with
//        o_beat_first/o_beat_last flags; o_busy while a word is held.
module stream_word_serializer_tx #(
  parameter int WORD_W = stream_link_pkg::DEF_WORD_W,
  parameter int BEAT_W = stream_link_pkg::DEF_BEAT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  input  logic [WORD_W-1:0] i_word_data,
  output logic              o_beat_valid,
  input  logic              i_beat_ready,
  output logic [BEAT_W-1:0] o_beat_data,
  output logic              o_beat_first,
  output logic              o_beat_last,
  output logic              o_busy
);

  import stream_link_pkg::*;

  localparam int BEATS = WORD_W / BEAT_W;
  localparam int IDX_W = idx_width(BEATS);

  // The word must split into a whole, non-zero number of beats.
  if ((BEAT_W < 1) || (WORD_W < BEAT_W) || ((WORD_W % BEAT_W) != 0)) begin : g_bad_width
    $error("stream_word_serializer_tx: WORD_W must be a non-zero multiple of BEAT_W");
  end

  tx_state_t         r_state;
  logic [WORD_W-1:0] r_word;

  logic [IDX_W-1:0]  w_idx;
  logic              w_first;
  logic              w_last;
  logic              w_send;
  logic              w_word_hs;
  logic              w_beat_hs;
  logic              w_final_beat;

  assign w_send       = (r_state == SEND);
  assign w_beat_hs    = w_send & i_beat_ready;
  assign w_final_beat = w_beat_hs & w_last;

  // Ready while empty, or when the final beat of the held word leaves this
  // cycle, which lets the next word slot in with no idle cycle.
  assign o_word_ready = ~w_send | (w_last & i_beat_ready);
  assign w_word_hs    = i_word_valid & o_word_ready;

  stream_beat_counter #(
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_beat_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_beat_hs & ~w_last),
    .i_clr   (w_word_hs | w_final_beat),
    .o_idx   (w_idx),
    .o_first (w_first),
    .o_last  (w_last)
  );

  // The word register only moves on a word handshake, so the beat mux output
  // stays frozen through any stall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_word  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_word_hs) begin
            r_word  <= i_word_data;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_final_beat) begin
            if (w_word_hs) begin
              r_word <= i_word_data;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_beat_valid = w_send;
  assign o_busy       = w_send;
  assign o_beat_first = w_send & w_first;
  assign o_beat_last  = w_send & w_last;
  assign o_beat_data  = r_word[int'(w_idx)*BEAT_W +: BEAT_W];

endmodule
